i2c_slave_buf: RTL and testbench
================================

I2C_SLAVE_BUF -- requirements
Module: i2c_slave_buf

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h21, 7-bit device address matched after START.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per RX and TX FIFO; power of two, at least 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on scl_i and sda_i; at least 2.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports scl_i and sda_i, input, 1 each, sampled bus lines.
REQ-007 SHALL have ports scl_o and sda_o, output, 1 each, open-drain drive; 0 pulls low, 1 releases.
REQ-008 SHALL have ports rx_data, output, 8, and rx_valid, output, 1: received bytes toward the user.
REQ-009 SHALL have port rx_ready, input, 1, user accepts rx_data.
REQ-010 SHALL have ports tx_data, input, 8, and tx_valid, input, 1: bytes from the user for master reads.
REQ-011 SHALL have port tx_ready, output, 1, high when the TX FIFO is not full.
REQ-012 SHALL have port busy, output, 1, high from an address match until STOP or address mismatch.
REQ-013 SHALL have port rx_overflow, output, 1, sticky; cleared only by rst.

Function
REQ-014 SHALL synchronise scl_i and sda_i through SYNC_STAGES flops and detect edges from the last two synchronised samples.
REQ-015 SHALL detect START as synchronised SDA falling while SCL is high, and STOP as SDA rising while SCL is high; each SHALL be flagged SYNC_STAGES+1 cycles after the pin change.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-017 SHALL go from any state to ADDR on START, including a repeated START, and from any state to IDLE on STOP.
REQ-018 SHALL shift bits MSB first on SCL rising; sda_o SHALL change only on a detected SCL falling edge.
REQ-019 In ADDR, after 8 bits, SHALL go to ADDR_ACK and drive sda_o=0 for one SCL period on a match; on a mismatch it SHALL go to WAIT_STOP with sda_o=1 throughout.
REQ-020 After ADDR_ACK, SHALL go to WR_DATA if R/W=0 and to RD_DATA if R/W=1.
REQ-021 In WR_DATA, the 8th bit SHALL complete the byte; the byte SHALL be pushed to the RX FIFO in the cycle of the following SCL falling edge, and the slave SHALL ACK it in WR_ACK.
REQ-022 On entering RD_DATA, SHALL pop the TX FIFO and drive its bits; RD_ACK SHALL sample the master's bit on SCL rising. ACK returns to RD_DATA; NACK goes to WAIT_STOP with sda_o released.
REQ-023 rx_valid SHALL equal RX FIFO not-empty; a pop SHALL occur when rx_valid and rx_ready are both high; FIFO read latency SHALL be zero (first-word fall-through).
REQ-024 SHALL push the TX FIFO when tx_valid and tx_ready are both high; simultaneous push and pop on either FIFO SHALL be allowed at any fill level except push-when-full.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be $clog2(FIFO_DEPTH)+1.

Reset
REQ-026 Under rst: state SHALL be IDLE, both FIFOs SHALL be flushed, scl_o=1, sda_o=1, rx_valid=0, tx_ready=1, busy=0, rx_overflow=0, rx_data=8'h00.
REQ-027 rst asserted mid-byte SHALL release both lines in the next cycle; the partial byte SHALL be discarded.

Configuration
REQ-028 With I2C_SLAVE_STRETCH_EN defined, a full RX FIFO at WR_ACK, or an empty TX FIFO on entering RD_DATA, SHALL hold scl_o=0 until space or data exists; the ACK or first bit SHALL then follow.
REQ-029 Without I2C_SLAVE_STRETCH_EN, scl_o SHALL stay 1: RX full SHALL NACK the byte, drop it and set rx_overflow; TX empty SHALL send 8'hFF.

Structure
REQ-030 Package i2c_pkg SHALL hold the state enum typedef and the constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
REQ-031 Both FIFOs SHALL instantiate one sub-module, sync_fifo, parametrised by width and depth.

Verification
REQ-032 Write address 0x21 with byte 0x5A, rx_ready=1: the address and data are ACKed, rx_data=0x5A is popped once, and busy falls after STOP.
REQ-033 Write address 0x22: no ACK, no RX push, busy stays 0, and sda_o stays 1.
REQ-034 Preload TX with 0x81 and 0x5A, then read 2 bytes with the master NACKing the 2nd: the master receives 0x81 and 0x5A, and the state reaches WAIT_STOP and then IDLE.
REQ-035 With rx_ready=0 and depth 4, write 5 bytes: with the macro, SCL is held low at the 5th ACK until one pop; without it, the 5th byte is NACKed and rx_overflow=1.
REQ-036 Write 0x33, then repeated START with a read of 1 byte: ADDR is re-entered without IDLE, 0x33 is in RX, and the read returns the TX head or 0xFF when TX is empty.
REQ-037 Assert rst after bit 4 of a write: both lines are released next cycle, the RX FIFO is empty, and the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the buffered I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need a defined value.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/i2c_slave_buf.sv
// Buffered I2C target: fixed 7-bit address, RX/TX byte FIFOs toward the user.
// Define I2C_SLAVE_STRETCH_EN to stretch SCL on RX full / TX empty instead of NACK / 0xFF.
module i2c_slave_buf
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h21,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_overflow
);

`ifdef I2C_SLAVE_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_q, sda_q;
    logic       scl_rise, scl_fall, start_det, stop_det, sda_smp;
    i2c_state_t state, state_nxt;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rw_bit, m_ack, sda_o_r, busy_r, overflow_r;
    logic       wr_wait, rd_wait;
    logic       byte_done, addr_hit, bus_event, push_req, load_req, do_load;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] rx_head, tx_head, rd_byte;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // NOTE: all sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_smp   <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q     <= scl_s;
            sda_q     <= sda_s;
            scl_rise  <= scl_s & ~scl_q;
            scl_fall  <= ~scl_s & scl_q;
            start_det <= scl_s & scl_q & sda_q & ~sda_s;
            stop_det  <= scl_s & scl_q & ~sda_q & sda_s;
            sda_smp   <= sda_s;
        end
    end

    assign byte_done = (bit_cnt == 4'd8);
    assign addr_hit  = (shift_reg[7:1] == SLAVE_ADDRESS);
    assign bus_event = start_det | stop_det;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        load_req  = 1'b0;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else if (scl_fall) begin
            case (state)
                ADDR:     if (byte_done) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: begin
                    state_nxt = rw_bit ? RD_DATA : WR_DATA;
                    load_req  = rw_bit;
                end
                WR_DATA:  if (byte_done) begin
                    state_nxt = WR_ACK;
                    push_req  = 1'b1;
                end
                WR_ACK:   if (!wr_wait) state_nxt = WR_DATA;
                RD_DATA:  if (byte_done && !rd_wait) state_nxt = RD_ACK;
                RD_ACK:   begin
                    state_nxt = (m_ack == I2C_ACK) ? RD_DATA : WAIT_STOP;
                    load_req  = (m_ack == I2C_ACK);
                end
                default:  ;
            endcase
        end
    end

    // A stalled push or load completes as soon as the FIFO allows it.
    assign rx_push = !rx_full && (push_req || (wr_wait && !bus_event));
    assign do_load = (load_req || (rd_wait && !bus_event)) && (!STRETCH || !tx_empty);
    assign tx_pop  = do_load && !tx_empty;
    assign rd_byte = tx_pop ? tx_head : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rw_bit     <= 1'b0;
            m_ack      <= I2C_NACK;
            sda_o_r    <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
            wr_wait    <= 1'b0;
            rd_wait    <= 1'b0;
        end else if (bus_event) begin
            bit_cnt <= '0;
            sda_o_r <= 1'b1;
            wr_wait <= 1'b0;
            rd_wait <= 1'b0;
            if (stop_det) busy_r <= 1'b0;
        end else begin
            if (scl_rise) begin
                if ((state == ADDR || state == WR_DATA || state == RD_DATA) && !byte_done)
                    bit_cnt <= bit_cnt + 4'd1;
                if (state == ADDR || state == WR_DATA)
                    shift_reg <= {shift_reg[6:0], sda_smp};
                if (state == RD_ACK)
                    m_ack <= sda_smp;
            end
            if (scl_fall) begin
                case (state)
                    ADDR: if (byte_done) begin
                        bit_cnt <= '0;
                        if (addr_hit) begin
                            sda_o_r <= I2C_ACK;
                            busy_r  <= 1'b1;
                            rw_bit  <= shift_reg[0];
                        end else begin
                            busy_r  <= 1'b0;
                        end
                    end
                    ADDR_ACK: begin
                        sda_o_r <= 1'b1;
                        bit_cnt <= '0;
                    end
                    WR_DATA: if (byte_done) begin
                        bit_cnt <= '0;
                        if (rx_full) begin
                            if (STRETCH) begin
                                wr_wait <= 1'b1;
                            end else begin
                                sda_o_r    <= I2C_NACK;
                                overflow_r <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: if (!wr_wait) sda_o_r <= 1'b1;
                    RD_DATA: if (!rd_wait) begin
                        if (byte_done) begin
                            sda_o_r <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            sda_o_r   <= shift_reg[6];
                        end
                    end
                    default: ;
                endcase
            end
            if (rx_push) begin
                sda_o_r <= I2C_ACK;
                wr_wait <= 1'b0;
            end
            if (load_req && STRETCH && tx_empty) rd_wait <= 1'b1;
            if (do_load) begin
                shift_reg <= rd_byte;
                sda_o_r   <= rd_byte[7];
                bit_cnt   <= '0;
                rd_wait   <= 1'b0;
            end
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .wr_data (shift_reg),
        .pop     (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push),
        .wr_data (tx_data),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign rx_valid    = !rx_empty;
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_data     = rx_valid ? rx_head : 8'h00;
    assign tx_ready    = !tx_full;
    assign tx_push     = tx_valid && tx_ready;
    assign scl_o       = !(wr_wait || rd_wait);
    assign sda_o       = sda_o_r;
    assign busy        = busy_r;
    assign rx_overflow = overflow_r;

endmodule

// File: tb/tb_i2c_slave_buf.sv
// Directed bench: bit-banged I2C master plus scoreboards for RX pops and master reads.
// Follows I2C_SLAVE_STRETCH_EN for the stretch-dependent expectations.
module tb_i2c_slave_buf;
    import i2c_pkg::*;

    localparam int Q        = 10;
    localparam int SCL_WAIT = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       bus_scl, bus_sda;
    logic       scl_o, sda_o;
    logic [7:0] rx_data, tx_data = 8'h00;
    logic       rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready;
    logic       busy, rx_overflow;

    int         n_checks = 0, n_errors = 0, rx_pops = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    bit         sda_low_seen, busy_seen, idle_seen;

    assign bus_scl = scl_m & scl_o;
    assign bus_sda = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_slave_buf dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (bus_scl),
        .sda_i       (bus_sda),
        .scl_o       (scl_o),
        .sda_o       (sda_o),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .rx_overflow (rx_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side of the RX path: every user pop must match the next expected byte.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (!sda_o) sda_low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (dut.state == IDLE) idle_seen = 1'b1;
            if (rx_valid && rx_ready) begin
                rx_pops++;
                check("rx_pop_expected", 32'(exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0) check("rx_data", rx_data, exp_rx.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic r);
        int t;
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        t = 0;
        while (bus_scl !== 1'b1 && t < SCL_WAIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= SCL_WAIT) check("scl_release_timeout", bus_scl, 1);
        tick(Q);
        r = bus_sda;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic rstart_cond();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            d[i] = r;
        end
        bit_io(nack, r);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        exp_rd.push_back(d);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         pops0;

        // Reset values while rst is held.
        rst = 1'b1;
        tick(5);
        check("rst_scl_o", scl_o, 1);
        check("rst_sda_o", sda_o, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", rx_overflow, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_state", dut.state, IDLE);
        rst = 1'b0;
        tick(5);

        // Write 0x5A to our address with the user always ready.
        rx_ready = 1'b1;
        start_cond();
        write_byte(8'h42, ack);
        check("w1_addr_ack", ack, I2C_ACK);
        check("w1_busy", busy, 1);
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check("w1_data_ack", ack, I2C_ACK);
        stop_cond();
        tick(10);
        check("w1_busy_after_stop", busy, 0);
        check("w1_pops", rx_pops, 1);

        // Foreign address: target must stay silent.
        sda_low_seen = 1'b0;
        busy_seen    = 1'b0;
        start_cond();
        write_byte(8'h44, ack);
        check("w2_addr_nack", ack, I2C_NACK);
        write_byte(8'h99, ack);
        check("w2_data_nack", ack, I2C_NACK);
        stop_cond();
        tick(10);
        check("w2_sda_never_low", sda_low_seen, 0);
        check("w2_busy_never", busy_seen, 0);
        check("w2_no_rx", rx_pops, 1);

        // Two-byte read, master NACKs the second.
        push_tx(8'h81);
        push_tx(8'h5A);
        start_cond();
        write_byte(8'h43, ack);
        check("r1_addr_ack", ack, I2C_ACK);
        read_byte(I2C_ACK, d);
        check("r1_byte0", d, exp_rd.pop_front());
        read_byte(I2C_NACK, d);
        check("r1_byte1", d, exp_rd.pop_front());
        check("r1_wait_stop", dut.state, WAIT_STOP);
        stop_cond();
        tick(10);
        check("r1_idle", dut.state, IDLE);

        // Fill the RX FIFO with the user stalled, then one byte beyond.
        rx_ready = 1'b0;
        pops0    = rx_pops;
        start_cond();
        write_byte(8'h42, ack);
        check("w4_addr_ack", ack, I2C_ACK);
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 << i;
            exp_rx.push_back(d);
            write_byte(d, ack);
            check("w4_fill_ack", ack, I2C_ACK);
        end
`ifdef I2C_SLAVE_STRETCH_EN
        exp_rx.push_back(8'h15);
        fork
            write_byte(8'h15, ack);
            begin : stretch_watch
                int t;
                t = 0;
                while (scl_o !== 1'b0 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                check("w4_stretch_low", scl_o, 0);
                tick(60);
                check("w4_stretch_held", scl_o, 0);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        check("w4_byte5_ack", ack, I2C_ACK);
        check("w4_no_overflow", rx_overflow, 0);
`else
        write_byte(8'h15, ack);
        check("w4_byte5_nack", ack, I2C_NACK);
        check("w4_overflow", rx_overflow, 1);
        check("w4_scl_free", scl_o, 1);
`endif
        stop_cond();
        rx_ready = 1'b1;
        tick(20);
        check("w4_drained", exp_rx.size(), 0);
`ifdef I2C_SLAVE_STRETCH_EN
        check("w4_pops", rx_pops - pops0, 5);
`else
        check("w4_pops", rx_pops - pops0, 4);
`endif

        // Write then repeated START into a one-byte read.
`ifdef I2C_SLAVE_STRETCH_EN
        push_tx(8'hC3);
`else
        exp_rd.push_back(8'hFF);
`endif
        start_cond();
        idle_seen = 1'b0;
        write_byte(8'h42, ack);
        check("w5_addr_ack", ack, I2C_ACK);
        exp_rx.push_back(8'h33);
        write_byte(8'h33, ack);
        check("w5_data_ack", ack, I2C_ACK);
        rstart_cond();
        check("w5_rstart_addr", dut.state, ADDR);
        write_byte(8'h43, ack);
        check("w5_raddr_ack", ack, I2C_ACK);
        read_byte(I2C_NACK, d);
        check("w5_read", d, exp_rd.pop_front());
        check("w5_no_idle", idle_seen, 0);
        stop_cond();
        tick(10);
        check("w5_rx_popped", exp_rx.size(), 0);

        // Reset in the middle of a data byte.
        start_cond();
        write_byte(8'h42, ack);
        check("w6_addr_ack", ack, I2C_ACK);
        for (int i = 7; i >= 4; i--) begin
            d = 8'hA5;
            bit_io(d[i], ack);
        end
        rst = 1'b1;
        @(negedge clk);
        check("w6_rst_scl", scl_o, 1);
        check("w6_rst_sda", sda_o, 1);
        check("w6_rst_state", dut.state, IDLE);
        tick(3);
        rst = 1'b0;
        stop_cond();
        tick(10);
        check("w6_rx_empty", rx_valid, 0);
        pops0 = rx_pops;
        start_cond();
        write_byte(8'h42, ack);
        check("w6_again_addr_ack", ack, I2C_ACK);
        exp_rx.push_back(8'h77);
        write_byte(8'h77, ack);
        check("w6_again_data_ack", ack, I2C_ACK);
        stop_cond();
        tick(10);
        check("w6_again_pops", rx_pops - pops0, 1);
        check("final_rx_queue", exp_rx.size(), 0);
        check("final_rd_queue", exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
